// File: rtl/count_capture_compare.sv
// count_capture_compare: extends an incoming count with a wrap counter, flags compare
// entries, and holds {wraps, count} snapshots behind a valid/ack handshake.
module count_capture_compare #(
    parameter int size       = 4,
    parameter int wrap_width = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [size-1:0]              count_i,
    input  logic [size-1:0]              cmp_value_i,
    input  logic                         capture_req_i,
    input  logic                         cap_ack_i,
    input  logic                         clear_i,
    output logic                         wrap_o,
    output logic                         match_o,
    output logic [wrap_width-1:0]        wrap_cnt_o,
    output logic                         wrap_ovf_o,
    output logic [wrap_width+size-1:0]   cap_data_o,
    output logic                         cap_valid_o,
    output logic                         overrun_o
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [size-1:0]            count_q;
    logic                       wrap_q, match_q, wrap_ovf_q, overrun_q;
    logic                       wrap_ovf_d, overrun_d;
    logic [wrap_width-1:0]      wrap_cnt_q, wrap_cnt_d, wrap_cnt_inc;
    logic [wrap_width+size-1:0] cap_data_q, cap_data_d, snap;
    logic [0:0]                 state_q, state_d;
    logic                       wrap_evt, match_evt, load;

    always_comb begin
        wrap_evt     = (count_q == '1) && (count_i == '0);
        match_evt    = (count_i == cmp_value_i) && (count_q != cmp_value_i);
        wrap_cnt_inc = wrap_cnt_q + wrap_width'(wrap_evt);
        // the snapshot includes a wrap landing in the same cycle
        snap         = {wrap_cnt_inc, count_i};
        load         = !clear_i && capture_req_i && (state_q == EMPTY || cap_ack_i);
        wrap_cnt_d   = clear_i ? '0 : wrap_cnt_inc;
        wrap_ovf_d   = clear_i ? 1'b0 : (wrap_ovf_q | (wrap_evt && wrap_cnt_q == '1));
        overrun_d    = clear_i ? 1'b0 :
                       (overrun_q | (state_q == FULL && capture_req_i && !cap_ack_i));
        cap_data_d   = load ? snap : cap_data_q;
        state_d      = clear_i ? EMPTY :
                       (state_q == EMPTY) ? (capture_req_i ? FULL : EMPTY) :
                       (cap_ack_i && !capture_req_i) ? EMPTY : FULL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            match_q    <= 1'b0;
            wrap_cnt_q <= '0;
            wrap_ovf_q <= 1'b0;
            overrun_q  <= 1'b0;
            cap_data_q <= '0;
            state_q    <= EMPTY;
        end else begin
            count_q    <= count_i;
            wrap_q     <= wrap_evt;
            match_q    <= match_evt;
            wrap_cnt_q <= wrap_cnt_d;
            wrap_ovf_q <= wrap_ovf_d;
            overrun_q  <= overrun_d;
            cap_data_q <= cap_data_d;
            state_q    <= state_d;
        end
    end

    assign wrap_o      = wrap_q;
    assign match_o     = match_q;
    assign wrap_cnt_o  = wrap_cnt_q;
    assign wrap_ovf_o  = wrap_ovf_q;
    assign cap_data_o  = cap_data_q;
    assign cap_valid_o = (state_q == FULL);
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_count_capture_compare.sv
// tb_count_capture_compare: directed test-plan steps plus random traffic against a
// wrap-total/pending-snapshot reference model.
module tb_count_capture_compare;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [3:0] count = '0, cmp = '0;
    logic       req = 1'b0, ack = 1'b0, clr = 1'b0;
    logic       wrap, match, wrap_ovf, cap_valid, overrun;
    logic [3:0] wrap_cnt;
    logic [7:0] cap_data;

    count_capture_compare #(.size(4), .wrap_width(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .count_i(count), .cmp_value_i(cmp),
        .capture_req_i(req), .cap_ack_i(ack), .clear_i(clr),
        .wrap_o(wrap), .match_o(match), .wrap_cnt_o(wrap_cnt), .wrap_ovf_o(wrap_ovf),
        .cap_data_o(cap_data), .cap_valid_o(cap_valid), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int         m_wraps;
    logic [3:0] m_prev;
    logic [7:0] m_cap;
    bit         m_wrap, m_match, m_valid, m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_wraps = 0; m_prev = '0; m_cap = '0;
        m_wrap = 0; m_match = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic chk_all();
        chk("wrap", wrap, m_wrap);
        chk("match", match, m_match);
        chk("wrap_cnt", wrap_cnt, m_wraps % 16);
        chk("wrap_ovf", wrap_ovf, m_wraps >= 16);
        chk("cap_valid", cap_valid, m_valid);
        chk("cap_data", cap_data, m_cap);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic cyc(input logic [3:0] c, input logic r = 0, input logic a = 0, input logic cl = 0);
        bit evt;
        count = c; req = r; ack = a; clr = cl;
        @(posedge clk);
        evt     = (m_prev == 4'd15) && (c == 4'd0);
        m_wrap  = evt;
        m_match = (c == cmp) && (m_prev != cmp);
        if (cl) begin
            m_wraps = 0; m_valid = 0; m_ovr = 0;
        end else begin
            if (r) begin
                if (!m_valid || a) begin
                    m_cap   = {4'((m_wraps + int'(evt)) % 16), c};
                    m_valid = 1;
                end else m_ovr = 1;
            end else if (a) m_valid = 0;
            m_wraps += int'(evt);
        end
        m_prev = c;
        #1 chk_all();
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) cyc(c);
    endtask

    task automatic wraps(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(4'd15); cyc(4'd0);
        end
    endtask

    initial begin
        mreset();
        #2 chk_all();
        #10 rst_n = 1'b1;
        // cmp=0 with count=0 straight out of reset: no match
        cyc(0); cyc(0);
        // wrap detection 14,15,0,1
        hold(14, 3); hold(15, 3);
        cyc(0);
        chk("t2_wrap_pulse", wrap, 1'b1);
        cyc(0);
        chk("t2_wrap_once", wrap, 1'b0);
        hold(0, 1); hold(1, 3);
        chk("t2_wrap_cnt", wrap_cnt, 4'd1);
        // entry-only compare
        cmp = 4'd5;
        cyc(4); cyc(5);
        chk("t3_match", match, 1'b1);
        cyc(5);
        chk("t3_match_once", match, 1'b0);
        cyc(5); cyc(6);
        // capture handshake
        wraps(1);
        cyc(7, 1);
        chk("t4_cap", cap_data, 8'h27);
        chk("t4_valid", cap_valid, 1'b1);
        cyc(8, 1);
        chk("t4_overrun", overrun, 1'b1);
        chk("t4_cap_held", cap_data, 8'h27);
        cyc(9, 1, 1);
        chk("t4_b2b", cap_data, 8'h29);
        chk("t4_b2b_valid", cap_valid, 1'b1);
        cyc(9, 0, 1);
        chk("t4_ack", cap_valid, 1'b0);
        // asynchronous reset mid-operation
        wraps(1);
        cyc(3, 1); cyc(4, 1);
        chk("t1_pre_cnt", wrap_cnt, 4'd3);
        #1 rst_n = 1'b0;
        #1 mreset();
        chk_all();
        chk("t1_cnt_async", wrap_cnt, 4'd0);
        #2 rst_n = 1'b1;
        // 16 wraps then clear
        cyc(2, 1);
        wraps(16);
        chk("t5_cnt_zero", wrap_cnt, 4'd0);
        chk("t5_ovf", wrap_ovf, 1'b1);
        cyc(3, 1);
        cyc(4, 1, 0, 1);
        chk("t5_clr_ovf", wrap_ovf, 1'b0);
        chk("t5_clr_valid", cap_valid, 1'b0);
        chk("t5_cap_kept", cap_data, 8'h02);
        // same-cycle wrap included in snapshot
        wraps(4);
        cyc(15);
        cyc(0, 1);
        chk("t6_cap", cap_data, 8'h50);
        chk("t6_cnt", wrap_cnt, 4'd5);
        chk("t6_wrap", wrap, 1'b1);
        cyc(1, 0, 1);
        chk("t6_wrap_once", wrap, 1'b0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : m_prev + 4'(($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 40) == 0) cmp = 4'($urandom);
            cyc(c, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 60) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_capture_compare.md
Name: count_capture_compare

Overview:
- Downstream consumer of the partitioned binary counter's count output.
- Detects counter wrap-around and extends the count with a wrap counter.
- Flags compare matches against a programmable value.
- Captures {wraps, count} snapshots on request and holds each until acknowledged, using a valid/ack handshake.

Parameters:
size, 4, width of the incoming count.
wrap_width, 4, width of the internal wrap counter (upper field of cap_data).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
count  input  size  count value from the counter datapath (changes only on clk posedge).
cmp_value  input  size  compare threshold; quasi-static.
capture_req  input  1  level, sampled each posedge; request a snapshot.
cap_ack  input  1  consumer accepts cap_data this cycle.
clear  input  1  synchronous clear of wrap/capture state.
wrap  output  1  one-cycle pulse per detected wrap.
match  output  1  one-cycle pulse when count enters cmp_value.
wrap_cnt  output  wrap_width  number of wraps, modulo 2^wrap_width.
wrap_ovf  output  1  sticky; set when wrap_cnt rolls over.
cap_data  output  wrap_width+size  captured {wrap_cnt, count}.
cap_valid  output  1  cap_data holds an unacknowledged snapshot.
overrun  output  1  sticky; set when a request is dropped.

Behaviour:
- Reset (rst=0, asynchronous, any time): all registers and outputs are 0, including count_q (internal previous-count register).
  - In-flight snapshots are lost.
  - The first posedge after rst deasserts behaves as a normal cycle.
- count_q <= count every posedge, regardless of clear.
- wrap_evt (comb) = (count_q == all-ones) && (count == 0).
- match_evt (comb) = (count == cmp_value) && (count_q != cmp_value).
  - Entry-only: count held at cmp_value for several cycles gives one pulse.
  - After reset with cmp_value=0 and count=0, no pulse.
- wrap <= wrap_evt; match <= match_evt.
  - Latency: 1 cycle after the count value appears on the input.
- wrap_cnt <= wrap_cnt + wrap_evt, modulo 2^wrap_width.
  - When wrap_cnt == all-ones and wrap_evt=1: wrap_cnt -> 0 and wrap_ovf <= 1 (sticky).
- Capture FSM, two states: EMPTY (cap_valid=0) and FULL (cap_valid=1).
  - Snapshot value: snap = {wrap_cnt + wrap_evt, count}, so a same-cycle wrap is included and the snapshot stays consistent.
  - EMPTY, capture_req=1: cap_data <= snap; go to FULL.
  - FULL, cap_ack=1, capture_req=0: go to EMPTY; cap_data retains its last value.
  - FULL, cap_ack=1, capture_req=1: cap_data <= snap; stay FULL (back-to-back, no bubble).
  - FULL, cap_ack=0, capture_req=1: request dropped; cap_data unchanged; overrun <= 1 (sticky).
  - cap_ack while EMPTY: ignored.
- clear=1 (synchronous, highest priority after rst):
  - wrap_cnt, wrap_ovf, overrun, cap_valid <= 0; FSM goes to EMPTY.
  - capture_req in the same cycle is ignored.
  - wrap/match pulses still generate from that cycle's events.
  - cap_data is not cleared.
- No combinational path from any input to any output.

Test Plan:
1. Reset mid-operation: reach wrap_cnt=3, cap_valid=1, overrun=1; pulse rst=0 between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
2. count 14,15,0,1 (one value per 3 cycles) -> wrap=1 for exactly one cycle, 1 cycle after count=0 appears; wrap_cnt=1; no pulse on 0->1.
3. cmp_value=5, count steps 4,5,5,5,6 -> match=1 for exactly one cycle after the first 5; cmp_value=0 with count=0 straight out of reset -> no match.
4. wrap_cnt=2, count=7, capture_req one cycle:
   - cap_valid=1, cap_data=8'h27.
   - Second req without ack -> overrun=1, cap_data stays 8'h27.
   - At count=9, req+ack in the same cycle -> cap_data=8'h29, cap_valid stays 1.
   - Ack alone -> cap_valid=0.
5. Drive 16 wraps -> wrap_cnt returns to 0, wrap_ovf=1; clear=1 -> wrap_ovf=0, overrun=0, cap_valid=0, cap_data unchanged.
6. wrap_cnt=4, count transitions 15->0 with capture_req=1 on the event cycle -> cap_data=8'h50, wrap_cnt=5, wrap pulses once.
